wbs_ctrl: RTL and testbench
===========================

WBS_CTRL -- requirements
Module: wbs_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 11, the width of one patch element.
REQ-002 SHALL have parameter LEAF_SIZE, default 8, the number of leaf memory banks.
REQ-003 SHALL have parameters PATCH_SIZE=5, ROW_SIZE=24, COL_SIZE=17, K=4 and NUM_LEAVES=64, with NUM_QUERYS=ROW_SIZE*COL_SIZE, QW=clog2(NUM_QUERYS) and LW=clog2(NUM_LEAVES).
REQ-004 SHALL use one clock and an asynchronous, active-low reset: wb_clk_i  in  1  clock; rst_n  in  1  reset.
REQ-005 SHALL have Wishbone slave inputs: wbs_stb_i, wbs_cyc_i, wbs_we_i (1 each); wbs_sel_i (4, ignored); wbs_dat_i (32); wbs_adr_i (32).
REQ-006 SHALL have Wishbone slave outputs: wbs_ack_o (1); wbs_dat_o (32).
REQ-007 SHALL have control outputs wbs_mode and wbs_debug (1 each).
REQ-008 SHALL have query-memory ports: wbs_qp_mem_csb0, wbs_qp_mem_web0 (out 1, active-low); wbs_qp_mem_addr0 (out QW); wbs_qp_mem_wpatch0 (out PATCH_SIZE*DATA_WIDTH=55); wbs_qp_mem_rpatch0 (in 55).
REQ-009 SHALL have leaf-memory ports: wbs_leaf_mem_csb0, wbs_leaf_mem_web0 (out LEAF_SIZE, one bit per bank, active-low); wbs_leaf_mem_addr0 (out LW); wbs_leaf_mem_wleaf0 (out 64); wbs_leaf_mem_rleaf0 (in 64 x LEAF_SIZE).
REQ-010 SHALL have node-memory ports: wbs_node_mem_web (out 1, active-low); wbs_node_mem_addr (out 32); wbs_node_mem_wdata (out 32); wbs_node_mem_rdata (in 32).

Function
REQ-011 SHALL accept a request when cyc&stb are high, the FSM is IDLE and ack is low, and SHALL decode adr[31:24] as: 0x30 registers, 0x31 query, 0x32 leaf, 0x33 best, 0x34 node.
REQ-012 SHALL implement FSM states IDLE, ISSUE, CAPTURE and ACK; a write goes IDLE->ISSUE->ACK and a read goes IDLE->ISSUE->CAPTURE->ACK.
REQ-013 SHALL hold wbs_ack_o high for exactly one cycle in ACK and then return to IDLE; a new request is accepted no earlier than the cycle after ack.
REQ-014 Registers: a write to 0x3000_0000 SHALL load wbs_mode<=dat_i[0]; a write to 0x3000_0001 SHALL load wbs_debug<=dat_i[0]; reads SHALL return the bit zero-extended to 32 bits.
REQ-015 Query region: address SHALL be adr[QW:1], half select adr[0] (0=bits 31:0, 1=bits 54:32).
REQ-016 Query read: in ISSUE, csb0=0 and web0=1 for one cycle; in CAPTURE, rpatch0 is sampled; dat_o SHALL return the selected half, with the upper half zero-extended.
REQ-017 Query write: a lower-half write SHALL only latch dat_i into a 32-bit holding register (no memory strobe); an upper-half write SHALL drive csb0=0, web0=0 for one cycle with wpatch0={dat_i[22:0], holding}.
REQ-018 Leaf region: half select adr[0]; bank = adr[clog2(LEAF_SIZE):1]; leaf address = adr[clog2(LEAF_SIZE)+LW:clog2(LEAF_SIZE)+1]; only the selected bank's csb/web bits SHALL toggle.
REQ-019 Leaf read/write SHALL follow REQ-016/017, with 64-bit data: wleaf0={dat_i, holding}; the upper read returns rleaf0[bank][63:32].
REQ-020 Node region: wbs_node_mem_addr SHALL be {8'h0, adr[23:0]} and be driven during ISSUE and CAPTURE.
REQ-021 Node write SHALL drive node_mem_web=0 for the ISSUE cycle with wdata=dat_i; a node read SHALL capture node_mem_rdata in CAPTURE into dat_o.
REQ-022 The best region (0x33) and undecoded addresses SHALL ack normally, return 0 on reads and ignore writes.
REQ-023 Idle values: all csb/web bits =1, node_mem_web=1, and memory address/data outputs hold their last value.
REQ-024 dat_o SHALL be registered and valid while ack is high; it holds its value otherwise.
REQ-025 Dropping cyc or stb mid-transaction SHALL NOT abort it; the FSM completes to ACK.

Reset
REQ-026 While rst_n=0, regardless of the clock: FSM=IDLE; ack=0; dat_o=0; mode=0; debug=0; holding register=0; all csb/web outputs =1; addresses and write data =0.
REQ-027 Reset asserted mid-transaction SHALL abort it with no ack and no further memory strobe.

Verification
REQ-028 Reset -> mode=0, debug=0, ack=0, qp csb0/web0=1, leaf csb0/web0=8'hFF, node_web=1.
REQ-029 Write 1 to 0x3000_0001, then to 0x3000_0000, then 0 to 0x3000_0001 -> one-cycle ack each; final mode=1, debug=0.
REQ-030 Read 0x3100_0002 with rpatch0=55'h00_1010_DEAD_BEEF -> addr0=1, csb0=0, web0=1 for one cycle; dat_o=0xDEADBEEF. Read 0x3100_0003 -> 0x0000_1010.
REQ-031 Write 0x0123_4567 to 0x3100_0004, then 0x000B_CDEF to 0x3100_0005 -> no strobe on the first write; a single strobe with addr0=2 and wpatch0=55'h0B_CDEF_0123_4567.
REQ-032 Read 0x3200_000E with rleaf0[7]=64'h1100_1010_DEAD_BEEF -> only bank 7 strobed, dat_o=0xDEADBEEF; upper (0x3200_000F) -> 0x1100_1010. Write 0x7654_3210 / 0xFEDC_BA98 to 0x3200_0006/7 -> bank 3 write with wleaf0=0xFEDCBA98_76543210.
REQ-033 Node write {10'b0, 11'd55, 11'd1} to 0x3400_0001 -> web=0 for one cycle, addr=1, wdata equal to the written value. Node read 0x3400_0001 with rdata=0x0000_0007 -> dat_o=0x0000_0007 at ack.

Source files
------------

// File: rtl/wbs_ctrl.sv
// rtl/wbs_ctrl.sv - Wishbone slave bridging register, query, leaf and node memories
module wbs_ctrl #(
    parameter int DATA_WIDTH = 11,
    parameter int LEAF_SIZE  = 8,
    parameter int PATCH_SIZE = 5,
    parameter int ROW_SIZE   = 24,
    parameter int COL_SIZE   = 17,
    parameter int K          = 4,
    parameter int NUM_LEAVES = 64,
    parameter int NUM_QUERYS = ROW_SIZE * COL_SIZE,
    parameter int QW         = $clog2(NUM_QUERYS),
    parameter int LW         = $clog2(NUM_LEAVES)
) (
    input  logic                               wb_clk_i,
    input  logic                               rst_n,
    input  logic                               wbs_stb_i,
    input  logic                               wbs_cyc_i,
    input  logic                               wbs_we_i,
    input  logic [3:0]                         wbs_sel_i,
    input  logic [31:0]                        wbs_dat_i,
    input  logic [31:0]                        wbs_adr_i,
    output logic                               wbs_ack_o,
    output logic [31:0]                        wbs_dat_o,
    output logic                               wbs_mode,
    output logic                               wbs_debug,
    output logic                               wbs_qp_mem_csb0,
    output logic                               wbs_qp_mem_web0,
    output logic [QW-1:0]                      wbs_qp_mem_addr0,
    output logic [PATCH_SIZE*DATA_WIDTH-1:0]   wbs_qp_mem_wpatch0,
    input  logic [PATCH_SIZE*DATA_WIDTH-1:0]   wbs_qp_mem_rpatch0,
    output logic [LEAF_SIZE-1:0]               wbs_leaf_mem_csb0,
    output logic [LEAF_SIZE-1:0]               wbs_leaf_mem_web0,
    output logic [LW-1:0]                      wbs_leaf_mem_addr0,
    output logic [63:0]                        wbs_leaf_mem_wleaf0,
    input  logic [64*LEAF_SIZE-1:0]            wbs_leaf_mem_rleaf0,
    output logic                               wbs_node_mem_web,
    output logic [31:0]                        wbs_node_mem_addr,
    output logic [31:0]                        wbs_node_mem_wdata,
    input  logic [31:0]                        wbs_node_mem_rdata
);

    localparam int PW = PATCH_SIZE * DATA_WIDTH;
    localparam int LB = $clog2(LEAF_SIZE);
    localparam logic [7:0] RGN_REG   = 8'h30;
    localparam logic [7:0] RGN_QUERY = 8'h31;
    localparam logic [7:0] RGN_LEAF  = 8'h32;
    localparam logic [7:0] RGN_NODE  = 8'h34;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_ACK} state_t;

    state_t            state_q, state_d;
    logic [31:0]       adr_q, adr_d;
    logic              we_q, we_d;
    logic              mode_q, mode_d, debug_q, debug_d;
    logic [31:0]       hold_q, hold_d, dat_q, dat_d;
    logic [QW-1:0]     qp_addr_q, qp_addr_d;
    logic [PW-1:0]     qp_wdata_q, qp_wdata_d;
    logic [LW-1:0]     leaf_addr_q, leaf_addr_d;
    logic [63:0]       leaf_wdata_q, leaf_wdata_d;
    logic [31:0]       node_addr_q, node_addr_d, node_wdata_q, node_wdata_d;

    logic              accept, issue, qp_hit, leaf_hit;
    logic [7:0]        rgn_i, rgn_q;
    logic [LB-1:0]     bank_q;
    logic [LEAF_SIZE-1:0] bank_oh;
    logic [63:0]       rleaf_sel;
    logic              unused_ok;

    assign rgn_i     = wbs_adr_i[31:24];
    assign rgn_q     = adr_q[31:24];
    assign bank_q    = adr_q[LB:1];
    assign bank_oh   = {{(LEAF_SIZE-1){1'b0}}, 1'b1} << bank_q;
    assign rleaf_sel = wbs_leaf_mem_rleaf0[{bank_q, 6'b0} +: 64];
    assign accept    = (state_q == S_IDLE) && wbs_cyc_i && wbs_stb_i && !wbs_ack_o;
    assign unused_ok = &{1'b0, wbs_sel_i, K[0]};

    always_comb begin
        state_d      = state_q;
        adr_d        = adr_q;
        we_d         = we_q;
        mode_d       = mode_q;
        debug_d      = debug_q;
        hold_d       = hold_q;
        dat_d        = dat_q;
        qp_addr_d    = qp_addr_q;
        qp_wdata_d   = qp_wdata_q;
        leaf_addr_d  = leaf_addr_q;
        leaf_wdata_d = leaf_wdata_q;
        node_addr_d  = node_addr_q;
        node_wdata_d = node_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_ISSUE;
                    adr_d   = wbs_adr_i;
                    we_d    = wbs_we_i;
                    // Address/data registers are loaded here so they are stable for the whole ISSUE cycle.
                    case (rgn_i)
                        RGN_REG: begin
                            if (wbs_we_i && wbs_adr_i[23:0] == 24'd0) mode_d = wbs_dat_i[0];
                            if (wbs_we_i && wbs_adr_i[23:0] == 24'd1) debug_d = wbs_dat_i[0];
                        end
                        RGN_QUERY: begin
                            qp_addr_d = wbs_adr_i[QW:1];
                            if (wbs_we_i && !wbs_adr_i[0]) hold_d = wbs_dat_i;
                            if (wbs_we_i && wbs_adr_i[0])  qp_wdata_d = {wbs_dat_i[PW-33:0], hold_q};
                        end
                        RGN_LEAF: begin
                            leaf_addr_d = wbs_adr_i[LB+LW:LB+1];
                            if (wbs_we_i && !wbs_adr_i[0]) hold_d = wbs_dat_i;
                            if (wbs_we_i && wbs_adr_i[0])  leaf_wdata_d = {wbs_dat_i, hold_q};
                        end
                        RGN_NODE: begin
                            node_addr_d = {8'h0, wbs_adr_i[23:0]};
                            if (wbs_we_i) node_wdata_d = wbs_dat_i;
                        end
                        default: ;
                    endcase
                end
            end
            S_ISSUE: state_d = we_q ? S_ACK : S_CAPTURE;
            S_CAPTURE: begin
                state_d = S_ACK;
                case (rgn_q)
                    RGN_REG: begin
                        if (adr_q[23:0] == 24'd0)      dat_d = {31'b0, mode_q};
                        else if (adr_q[23:0] == 24'd1) dat_d = {31'b0, debug_q};
                        else                           dat_d = 32'b0;
                    end
                    RGN_QUERY: dat_d = adr_q[0] ? {{(64-PW){1'b0}}, wbs_qp_mem_rpatch0[PW-1:32]}
                                                : wbs_qp_mem_rpatch0[31:0];
                    RGN_LEAF:  dat_d = adr_q[0] ? rleaf_sel[63:32] : rleaf_sel[31:0];
                    RGN_NODE:  dat_d = wbs_node_mem_rdata;
                    default:   dat_d = 32'b0;
                endcase
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            adr_q        <= '0;
            we_q         <= 1'b0;
            mode_q       <= 1'b0;
            debug_q      <= 1'b0;
            hold_q       <= '0;
            dat_q        <= '0;
            qp_addr_q    <= '0;
            qp_wdata_q   <= '0;
            leaf_addr_q  <= '0;
            leaf_wdata_q <= '0;
            node_addr_q  <= '0;
            node_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            adr_q        <= adr_d;
            we_q         <= we_d;
            mode_q       <= mode_d;
            debug_q      <= debug_d;
            hold_q       <= hold_d;
            dat_q        <= dat_d;
            qp_addr_q    <= qp_addr_d;
            qp_wdata_q   <= qp_wdata_d;
            leaf_addr_q  <= leaf_addr_d;
            leaf_wdata_q <= leaf_wdata_d;
            node_addr_q  <= node_addr_d;
            node_wdata_q <= node_wdata_d;
        end
    end

    // A lower-half write only fills the holding register, so it never strobes a memory.
    assign issue    = (state_q == S_ISSUE);
    assign qp_hit   = issue && (rgn_q == RGN_QUERY) && (!we_q || adr_q[0]);
    assign leaf_hit = issue && (rgn_q == RGN_LEAF) && (!we_q || adr_q[0]);

    assign wbs_qp_mem_csb0     = !qp_hit;
    assign wbs_qp_mem_web0     = !(qp_hit && we_q);
    assign wbs_leaf_mem_csb0   = ~({LEAF_SIZE{leaf_hit}} & bank_oh);
    assign wbs_leaf_mem_web0   = ~({LEAF_SIZE{leaf_hit && we_q}} & bank_oh);
    assign wbs_node_mem_web    = !(issue && (rgn_q == RGN_NODE) && we_q);

    assign wbs_ack_o           = (state_q == S_ACK);
    assign wbs_dat_o           = dat_q;
    assign wbs_mode            = mode_q;
    assign wbs_debug           = debug_q;
    assign wbs_qp_mem_addr0    = qp_addr_q;
    assign wbs_qp_mem_wpatch0  = qp_wdata_q;
    assign wbs_leaf_mem_addr0  = leaf_addr_q;
    assign wbs_leaf_mem_wleaf0 = leaf_wdata_q;
    assign wbs_node_mem_addr   = node_addr_q;
    assign wbs_node_mem_wdata  = node_wdata_q;

endmodule

// File: tb/tb_wbs_ctrl.sv
// tb/tb_wbs_ctrl.sv - randomized self-checking bench for wbs_ctrl against a behavioural model
module tb_wbs_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         stb = 1'b0, cyc = 1'b0, we_s = 1'b0;
    logic [3:0]   sel = 4'hF;
    logic [31:0]  dat_s = '0, adr_s = '0;
    logic         ack;
    logic [31:0]  dat_o;
    logic         mode, debug;
    logic         qp_csb, qp_web;
    logic [8:0]   qp_addr;
    logic [54:0]  qp_wpatch, qp_rpatch;
    logic [7:0]   leaf_csb, leaf_web;
    logic [5:0]   leaf_addr;
    logic [63:0]  wleaf;
    logic [511:0] rleaf;
    logic         node_web;
    logic [31:0]  node_addr, node_wdata, node_rdata;

    always #5 clk = ~clk;

    wbs_ctrl dut (
        .wb_clk_i(clk), .rst_n(rst_n),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we_s), .wbs_sel_i(sel),
        .wbs_dat_i(dat_s), .wbs_adr_i(adr_s), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .wbs_mode(mode), .wbs_debug(debug),
        .wbs_qp_mem_csb0(qp_csb), .wbs_qp_mem_web0(qp_web), .wbs_qp_mem_addr0(qp_addr),
        .wbs_qp_mem_wpatch0(qp_wpatch), .wbs_qp_mem_rpatch0(qp_rpatch),
        .wbs_leaf_mem_csb0(leaf_csb), .wbs_leaf_mem_web0(leaf_web), .wbs_leaf_mem_addr0(leaf_addr),
        .wbs_leaf_mem_wleaf0(wleaf), .wbs_leaf_mem_rleaf0(rleaf),
        .wbs_node_mem_web(node_web), .wbs_node_mem_addr(node_addr),
        .wbs_node_mem_wdata(node_wdata), .wbs_node_mem_rdata(node_rdata)
    );

    // Environment: synchronous SRAMs driven by the DUT
    logic [54:0] envq [512];
    logic [63:0] envl [8][64];
    logic [31:0] envn [64];

    always @(posedge clk) begin
        if (!qp_csb) begin
            if (!qp_web) envq[qp_addr] = qp_wpatch;
            else         qp_rpatch <= envq[qp_addr];
        end
        for (int b = 0; b < 8; b++) begin
            if (!leaf_csb[b]) begin
                if (!leaf_web[b]) envl[b][leaf_addr] = wleaf;
                else              rleaf[b*64 +: 64] <= envl[b][leaf_addr];
            end
        end
        node_rdata <= envn[node_addr[5:0]];
        if (!node_web) envn[node_addr[5:0]] = node_wdata;
    end

    // Monitor: strobe and ack activity counted once per cycle
    int          n_qcs = 0, n_qwe = 0, n_nwe = 0, n_ack = 0;
    int          n_lcs [8], n_lwe [8];
    logic [8:0]  m_qaddr;
    logic [54:0] m_wpatch;
    logic [5:0]  m_laddr;
    logic [63:0] m_wleaf;
    logic [31:0] m_naddr, m_nwdata;

    initial for (int b = 0; b < 8; b++) begin n_lcs[b] = 0; n_lwe[b] = 0; end

    always @(negedge clk) begin
        if (!qp_csb) begin n_qcs++; m_qaddr = qp_addr; end
        if (!qp_web) begin n_qwe++; m_wpatch = qp_wpatch; end
        for (int b = 0; b < 8; b++) begin
            if (!leaf_csb[b]) begin n_lcs[b]++; m_laddr = leaf_addr; end
            if (!leaf_web[b]) begin n_lwe[b]++; m_wleaf = wleaf; end
        end
        if (!node_web) begin n_nwe++; m_naddr = node_addr; m_nwdata = node_wdata; end
        if (ack) n_ack++;
    end

    // Reference model state
    logic [54:0] refq [512];
    logic [63:0] refl [8][64];
    logic [31:0] refn [64];
    logic        r_mode = 1'b0, r_debug = 1'b0;
    logic [31:0] r_hold = '0;

    int n_checks = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic run_op(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input bit drop, output logic [31:0] rd);
        logic [7:0]  rgn, e_lcs, e_lwe, o_lcs, o_lwe;
        logic        half;
        int          qa, la, bk, na, t, lcnt;
        int          e_qcs, e_qwe, e_nwe;
        logic [31:0] e_rd;
        logic [54:0] e_wp;
        logic [63:0] e_wl;
        int          s_qcs, s_qwe, s_nwe, s_ack;
        int          s_lcs [8], s_lwe [8];

        rgn = adr[31:24]; half = adr[0];
        qa = int'(adr[9:1]); la = int'(adr[9:4]); bk = int'(adr[3:1]); na = int'(adr[5:0]);
        e_qcs = 0; e_qwe = 0; e_nwe = 0; e_lcs = '0; e_lwe = '0; e_rd = '0; e_wp = '0; e_wl = '0;
        case (rgn)
            8'h30: if (we) begin
                       if (adr[23:0] == 0) r_mode = dat[0]; else r_debug = dat[0];
                   end else e_rd = (adr[23:0] == 0) ? {31'b0, r_mode} : {31'b0, r_debug};
            8'h31: if (we && !half) r_hold = dat;
                   else if (we) begin
                       refq[qa] = {dat[22:0], r_hold}; e_wp = refq[qa]; e_qcs = 1; e_qwe = 1;
                   end else begin
                       e_qcs = 1; e_rd = half ? 32'(refq[qa] >> 32) : refq[qa][31:0];
                   end
            8'h32: if (we && !half) r_hold = dat;
                   else if (we) begin
                       refl[bk][la] = {dat, r_hold}; e_wl = refl[bk][la];
                       e_lcs = 8'(1 << bk); e_lwe = e_lcs;
                   end else begin
                       e_lcs = 8'(1 << bk); e_rd = half ? refl[bk][la][63:32] : refl[bk][la][31:0];
                   end
            8'h34: if (we) begin refn[na] = dat; e_nwe = 1; end
                   else e_rd = refn[na];
            default: ;
        endcase

        s_qcs = n_qcs; s_qwe = n_qwe; s_nwe = n_nwe; s_ack = n_ack;
        for (int b = 0; b < 8; b++) begin s_lcs[b] = n_lcs[b]; s_lwe[b] = n_lwe[b]; end

        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we_s = we; adr_s = adr; dat_s = dat;
        @(posedge clk); #1;
        if (drop) begin cyc = 1'b0; stb = 1'b0; end
        t = 0;
        do begin @(negedge clk); t++; end while (!ack && t < 8);
        chk("ack_latency", 64'(t), we ? 64'd2 : 64'd3);
        rd = dat_o;
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk); #1;
        chk("ack_one_cycle", 64'(n_ack - s_ack), 64'd1);
        if (!we) chk($sformatf("rdata_%0h", adr), 64'(rd), 64'(e_rd));

        chk("qp_csb_cycles", 64'(n_qcs - s_qcs), 64'(e_qcs));
        chk("qp_web_cycles", 64'(n_qwe - s_qwe), 64'(e_qwe));
        chk("node_web_cycles", 64'(n_nwe - s_nwe), 64'(e_nwe));
        o_lcs = '0; o_lwe = '0; lcnt = 0;
        for (int b = 0; b < 8; b++) begin
            o_lcs[b] = (n_lcs[b] != s_lcs[b]); o_lwe[b] = (n_lwe[b] != s_lwe[b]);
            lcnt += n_lcs[b] - s_lcs[b];
        end
        chk("leaf_csb_banks", 64'(o_lcs), 64'(e_lcs));
        chk("leaf_web_banks", 64'(o_lwe), 64'(e_lwe));
        chk("leaf_cycles", 64'(lcnt), (e_lcs != 0) ? 64'd1 : 64'd0);
        if (e_qcs != 0) chk("qp_addr", 64'(m_qaddr), 64'(qa));
        if (e_qwe != 0) chk("qp_wpatch", 64'(m_wpatch), 64'(e_wp));
        if (e_lcs != 0) chk("leaf_addr", 64'(m_laddr), 64'(la));
        if (e_lwe != 0) chk("leaf_wleaf", m_wleaf, e_wl);
        if (e_nwe != 0) begin
            chk("node_addr", 64'(m_naddr), {40'b0, adr[23:0]});
            chk("node_wdata", 64'(m_nwdata), 64'(dat));
        end
        chk("mode", 64'(mode), 64'(r_mode));
        chk("debug", 64'(debug), 64'(r_debug));
    endtask

    logic [31:0] rd;
    logic [31:0] a;
    int          s_qcs0, s_ack0;

    initial begin
        for (int i = 0; i < 512; i++) begin envq[i] = {$urandom, $urandom}; refq[i] = envq[i]; end
        for (int b = 0; b < 8; b++)
            for (int i = 0; i < 64; i++) begin envl[b][i] = {$urandom, $urandom}; refl[b][i] = envl[b][i]; end
        for (int i = 0; i < 64; i++) begin envn[i] = $urandom; refn[i] = envn[i]; end

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ack", 64'(ack), 0);
        chk("rst_dat", 64'(dat_o), 0);
        chk("rst_mode", 64'(mode), 0);
        chk("rst_debug", 64'(debug), 0);
        chk("rst_qp_csb_web", {62'b0, qp_csb, qp_web}, 64'h3);
        chk("rst_leaf_csb", 64'(leaf_csb), 64'hFF);
        chk("rst_leaf_web", 64'(leaf_web), 64'hFF);
        chk("rst_node_web", 64'(node_web), 1);
        chk("rst_addr_zero", {qp_addr, leaf_addr, node_addr}, 0);
        chk("rst_wdata_zero", {qp_wpatch, 9'b0} | wleaf | 64'(node_wdata), 0);
        rst_n = 1'b1;

        // Register sequence
        run_op(1, 32'h3000_0001, 32'h1, 0, rd);
        run_op(1, 32'h3000_0000, 32'h1, 0, rd);
        run_op(1, 32'h3000_0001, 32'h0, 0, rd);
        chk("final_mode_debug", {62'b0, mode, debug}, 64'h2);
        run_op(0, 32'h3000_0000, 32'h0, 0, rd);
        chk("reg_read_mode", 64'(rd), 64'h1);

        // Query read and split write
        envq[1] = 55'h00_1010_DEAD_BEEF; refq[1] = envq[1];
        run_op(0, 32'h3100_0002, 32'h0, 0, rd);
        chk("q_read_lo", 64'(rd), 64'hDEAD_BEEF);
        run_op(0, 32'h3100_0003, 32'h0, 1, rd);
        chk("q_read_hi", 64'(rd), 64'h0000_1010);
        run_op(1, 32'h3100_0004, 32'h0123_4567, 0, rd);
        run_op(1, 32'h3100_0005, 32'h000B_CDEF, 0, rd);
        chk("q_mem_word2", 64'(envq[2]), 64'h0B_CDEF_0123_4567);

        // Leaf read and split write
        envl[7][0] = 64'h1100_1010_DEAD_BEEF; refl[7][0] = envl[7][0];
        run_op(0, 32'h3200_000E, 32'h0, 0, rd);
        chk("l_read_lo", 64'(rd), 64'hDEAD_BEEF);
        run_op(0, 32'h3200_000F, 32'h0, 0, rd);
        chk("l_read_hi", 64'(rd), 64'h1100_1010);
        run_op(1, 32'h3200_0006, 32'h7654_3210, 0, rd);
        run_op(1, 32'h3200_0007, 32'hFEDC_BA98, 1, rd);
        chk("l_mem_bank3", envl[3][0], 64'hFEDC_BA98_7654_3210);

        // Node write and read
        run_op(1, 32'h3400_0001, {10'b0, 11'd55, 11'd1}, 0, rd);
        chk("n_mem_word1", 64'(envn[1]), 64'h0001_B801);
        envn[1] = 32'h7; refn[1] = 32'h7;
        run_op(0, 32'h3400_0001, 32'h0, 0, rd);
        chk("n_read", 64'(rd), 64'h7);

        // Best region and undecoded
        run_op(0, 32'h3300_0004, 32'h0, 0, rd);
        run_op(1, 32'h1234_5678, 32'hFFFF_FFFF, 0, rd);

        // Reset mid-transaction aborts an upper query write
        run_op(1, 32'h3100_0010, 32'hAAAA_5555, 0, rd);
        s_qcs0 = n_qcs; s_ack0 = n_ack;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we_s = 1'b1; adr_s = 32'h3100_0011; dat_s = 32'h0055_AA55;
        @(posedge clk); #1;
        chk("abort_issue_strobe", 64'(qp_csb), 0);
        rst_n = 1'b0; #1;
        chk("abort_strobe_off", {62'b0, qp_csb, qp_web}, 64'h3);
        cyc = 1'b0; stb = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_no_ack", 64'(n_ack - s_ack0), 0);
        chk("abort_no_strobe", 64'(n_qcs - s_qcs0), 0);
        chk("abort_mode_cleared", 64'(mode), 0);
        r_mode = 1'b0; r_debug = 1'b0; r_hold = '0;
        rst_n = 1'b1;
        run_op(0, 32'h3100_0011, 32'h0, 0, rd);

        // Randomized traffic against the reference model
        for (int i = 0; i < 150; i++) begin
            int sel_r;
            logic w;
            sel_r = $urandom_range(0, 9);
            w = 1'($urandom_range(0, 1));
            case (sel_r)
                0:          a = {8'h30, 23'b0, 1'($urandom_range(0, 1))};
                1, 2, 3:    a = {8'h31, 14'b0, 9'($urandom_range(0, 511)), 1'($urandom_range(0, 1))};
                4, 5, 6:    a = {8'h32, 14'b0, 6'($urandom_range(0, 63)), 3'($urandom_range(0, 7)),
                                 1'($urandom_range(0, 1))};
                7, 8:       a = {8'h34, 18'b0, 6'($urandom_range(0, 63))};
                default:    a = {($urandom_range(0, 1) != 0) ? 8'h33 : 8'($urandom_range(0, 47)),
                                 24'($urandom)};
            endcase
            run_op(w, a, $urandom, ($urandom_range(0, 3) == 0), rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
